// File: rtl/wb_conbus_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect.
//   state_t   : arbiter/bus FSM states (IDLE, GRANT, ERR)
//   WB_ADR_W  : Wishbone address width
//   WB_DAT_W  : Wishbone data width
//   WB_SEL_W  : Wishbone byte-select width
package wb_conbus_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ERR   = 2'd2
  } state_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin selector.
//   req        : request vector, one bit per master
//   last_grant : index of the master granted most recently
//   grant      : first requesting index found searching upward from
//                last_grant+1 with wrap-around
//   valid      : at least one request is present
module wb_rr_arbiter #(
  parameter int NM = 4,
  parameter int GW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          valid
);

  // Two priority groups: indices above last_grant beat those at or below it.
  // Each loop runs downward so the lowest index of a group is written last;
  // the second loop overrides the first, giving the upper group precedence.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int j = NM - 1; j >= 0; j--) begin
      if (req[j] && (GW'(j) <= last_grant)) begin
        grant = GW'(j);
        valid = 1'b1;
      end
    end
    for (int j = NM - 1; j >= 0; j--) begin
      if (req[j] && (GW'(j) > last_grant)) begin
        grant = GW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arb_conbus.sv
// Wishbone shared-bus interconnect: NM masters arbitrated round-robin onto
// one shared bus that is address-decoded to NS slaves.
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   m_adr_i/m_dat_i/m_sel_i/
//   m_we_i/m_cyc_i/m_stb_i    : packed master requests (slice i = master i)
//   m_dat_o                   : read data returned to all masters
//   m_ack_o, m_err_o          : per-master acknowledge / error
//   s_adr_o/s_dat_o/s_sel_o/
//   s_we_o                    : shared slave-side request fields
//   s_cyc_o, s_stb_o          : per-slave cycle / strobe
//   s_dat_i, s_ack_i          : packed slave responses
// Optional feature: define WB_CONBUS_TIMEOUT_EN to add a watchdog that
// errors out a strobe left unacknowledged for TIMEOUT cycles.
module wb_arb_conbus
  import wb_conbus_pkg::*;
#(
  parameter int                      NM       = 4,
  parameter int                      NS       = 4,
  parameter int                      S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0]  S_ADDR   = {3'd3, 3'd2, 3'd1, 3'd0},
  parameter int                      TIMEOUT  = 255
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NM*WB_ADR_W-1:0] m_adr_i,
  input  logic [NM*WB_DAT_W-1:0] m_dat_i,
  input  logic [NM*WB_SEL_W-1:0] m_sel_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  output logic [WB_DAT_W-1:0]    m_dat_o,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  output logic [WB_ADR_W-1:0]    s_adr_o,
  output logic [WB_DAT_W-1:0]    s_dat_o,
  output logic [WB_SEL_W-1:0]    s_sel_o,
  output logic                   s_we_o,
  output logic [NS-1:0]          s_cyc_o,
  output logic [NS-1:0]          s_stb_o,
  input  logic [NS*WB_DAT_W-1:0] s_dat_i,
  input  logic [NS-1:0]          s_ack_i
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   last_grant, last_grant_nxt;
  logic [GW-1:0]   arb_grant;
  logic            arb_valid;

  logic [WB_ADR_W-1:0] g_adr;
  logic [WB_DAT_W-1:0] g_dat;
  logic [WB_SEL_W-1:0] g_sel;
  logic                g_we, g_cyc, g_stb;
  logic [SW-1:0]       sel_idx;
  logic                sel_hit;
  logic [WB_DAT_W-1:0] sel_dat;
  logic                sel_ack;
  logic                slave_en;
  logic                wd_expire;

  wb_rr_arbiter #(.NM(NM), .GW(GW)) u_arb (
    .req        (m_cyc_i),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Granted-master mux and address decode (lowest matching slave wins).
  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (grant == GW'(i)) begin
        g_adr = m_adr_i[i*WB_ADR_W +: WB_ADR_W];
        g_dat = m_dat_i[i*WB_DAT_W +: WB_DAT_W];
        g_sel = m_sel_i[i*WB_SEL_W +: WB_SEL_W];
        g_we  = m_we_i[i];
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
      end
    end

    sel_idx = '0;
    sel_hit = 1'b0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (g_adr[WB_ADR_W-1 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
        sel_idx = SW'(k);
        sel_hit = 1'b1;
      end
    end

    sel_dat = '0;
    sel_ack = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (sel_idx == SW'(k)) begin
        sel_dat = s_dat_i[k*WB_DAT_W +: WB_DAT_W];
        sel_ack = s_ack_i[k];
      end
    end
  end

  // Bus outputs: slaves only see a cycle while GRANT holds a live master cycle.
  always_comb begin
    slave_en = (state == GRANT) && g_cyc && sel_hit;
    s_adr_o  = g_adr;
    s_dat_o  = g_dat;
    s_sel_o  = g_sel;
    s_we_o   = g_we;
    m_dat_o  = slave_en ? sel_dat : '0;
    for (int k = 0; k < NS; k++) begin
      s_cyc_o[k] = slave_en && (sel_idx == SW'(k));
      s_stb_o[k] = slave_en && g_stb && (sel_idx == SW'(k));
    end
    for (int i = 0; i < NM; i++) begin
      m_ack_o[i] = slave_en && g_stb && sel_ack && (grant == GW'(i));
      m_err_o[i] = (state == ERR) && (grant == GW'(i));
    end
  end

`ifdef WB_CONBUS_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_stall;

  // wd_cnt holds the number of earlier stalled cycles, so the strobe is
  // visible for exactly TIMEOUT cycles before ERR takes over.
  assign wd_stall  = slave_en && g_stb && !sel_ack;
  assign wd_expire = wd_stall && (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_cnt <= '0;
    end else if (wd_stall && !wd_expire) begin
      wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          grant_nxt = arb_grant;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end else if (g_stb && !sel_hit) begin
          state_nxt = ERR;
        end else if (wd_expire) begin
          state_nxt = ERR;
        end
      end
      ERR:     state_nxt = GRANT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NM - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arb_conbus.sv
`timescale 1ns/1ps
module tb_wb_arb_conbus;

  localparam int NM = 4;
  localparam int NS = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*32-1:0]  m_adr_i;
  logic [NM*32-1:0]  m_dat_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i;
  logic [NM-1:0]     m_cyc_i;
  logic [NM-1:0]     m_stb_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic [31:0]       s_adr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o;
  logic [NS-1:0]     s_stb_o;
  logic [NS*32-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i;
  logic [NS-1:0]     ack_man;
  logic              ack_auto;

  always #5 clk = ~clk;

  // Slave model: either ack whatever is strobed (zero wait) or a manual vector.
  assign s_ack_i = ack_auto ? s_stb_o : ack_man;

  wb_arb_conbus #(
    .NM(NM), .NS(NS), .S_ADDR_W(3),
    .S_ADDR({3'd3, 3'd2, 3'd1, 3'd0}), .TIMEOUT(TO)
  ) dut (
    .sys_clk(clk), .sys_rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic        stb;
    logic [3:0]  ack;
    logic [3:0]  exp_cyc;
    logic [3:0]  exp_stb;
    logic [3:0]  exp_mack;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[7];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] adr, input logic [31:0] dat,
                       input logic we, input logic cyc, input logic stb);
    m_adr_i[i*32 +: 32] = adr;
    m_dat_i[i*32 +: 32] = dat;
    m_sel_i[i*4 +: 4]   = dat[3:0];
    m_we_i[i]           = we;
    m_cyc_i[i]          = cyc;
    m_stb_i[i]          = stb;
  endtask

  task automatic default_sdat();
    for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = 32'hA000_0000 | 32'(k);
  endtask

  task automatic all_idle();
    m_cyc_i = '0;
    m_stb_i = '0;
    ack_auto = 1'b0;
    ack_man = '0;
    step();
    step();
    step();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_s_cyc"}, 32'(s_cyc_o), 32'h0);
    chk({tag, "_s_stb"}, 32'(s_stb_o), 32'h0);
    chk({tag, "_m_ack"}, 32'(m_ack_o), 32'h0);
    chk({tag, "_m_err"}, 32'(m_err_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench exceeded time limit");
  end

  initial begin
    int n_stb;
    int got_err;
    int ngr;
    int idx;
    int order[6];
    logic [2:0] drop;

    tbl[0] = '{32'h0000_0010, 32'h1111_111F, 1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 32'hA000_0000};
    tbl[1] = '{32'h4000_0020, 32'h2222_2223, 1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 32'hA000_0002};
    tbl[2] = '{32'h6000_0000, 32'h3333_3335, 1'b1, 1'b1, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 32'hA000_0003};
    tbl[3] = '{32'h6000_0000, 32'h4444_4447, 1'b0, 1'b1, 4'b0001, 4'b1000, 4'b1000, 4'b0000, 32'hA000_0003};
    tbl[4] = '{32'h2000_0000, 32'h5555_5559, 1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 32'hA000_0001};
    tbl[5] = '{32'h3FFF_FFFC, 32'h6666_666C, 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 32'hA000_0001};
    tbl[6] = '{32'h1FFF_FFFF, 32'h7777_777E, 1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 32'hA000_0000};

    rst = 1'b1;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0;
    ack_auto = 1'b0; ack_man = '0;
    default_sdat();
    step();
    step();

    // Reset holds the bus quiet even with requests pending.
    m_cyc_i = 4'b0011;
    m_stb_i = 4'b0011;
    #1;
    chk_quiet("rst");
    step();
    m_cyc_i = '0;
    m_stb_i = '0;
    rst = 1'b0;
    step();

    // Single read from slave 1, ack one cycle after the strobe appears.
    s_dat_i[1*32 +: 32] = 32'hDEAD_BEEF;
    set_m(0, 32'h2000_0004, 32'h0000_000F, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rd_idle_stb", 32'(s_stb_o), 32'h0);
    step();
    chk("rd_s_stb", 32'(s_stb_o), 32'h2);
    chk("rd_s_adr", s_adr_o, 32'h2000_0004);
    chk("rd_noack_yet", 32'(m_ack_o), 32'h0);
    step();
    ack_man = 4'b0010;
    #1;
    chk("rd_m_ack", 32'(m_ack_o), 32'h1);
    chk("rd_m_dat", m_dat_o, 32'hDEAD_BEEF);
    step();
    set_m(0, 32'h2000_0004, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    ack_man = '0;
    #1;
    chk("rd_cyc_fall", 32'(s_cyc_o), 32'h0);
    default_sdat();
    all_idle();

    // Routing/decode table on master 1 (last_grant=0 so master 1 wins),
    // with master 0 waiting throughout.
    set_m(1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    set_m(0, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      set_m(1, tbl[i].adr, tbl[i].dat, tbl[i].we, 1'b1, tbl[i].stb);
      ack_man = tbl[i].ack;
      #1;
      chk($sformatf("tbl%0d_s_cyc", i), 32'(s_cyc_o), 32'(tbl[i].exp_cyc));
      chk($sformatf("tbl%0d_s_stb", i), 32'(s_stb_o), 32'(tbl[i].exp_stb));
      chk($sformatf("tbl%0d_m_ack", i), 32'(m_ack_o), 32'(tbl[i].exp_mack));
      chk($sformatf("tbl%0d_m_err", i), 32'(m_err_o), 32'h0);
      chk($sformatf("tbl%0d_m_dat", i), m_dat_o, tbl[i].exp_dat);
      chk($sformatf("tbl%0d_s_adr", i), s_adr_o, tbl[i].adr);
      chk($sformatf("tbl%0d_s_dat", i), s_dat_o, tbl[i].dat);
      chk($sformatf("tbl%0d_s_sel", i), 32'(s_sel_o), 32'(tbl[i].dat[3:0]));
      chk($sformatf("tbl%0d_s_we", i), 32'(s_we_o), 32'(tbl[i].we));
      step();
    end
    // Master 1 releases; the waiting master 0 is then served.
    set_m(1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    ack_man = '0;
    ack_auto = 1'b1;
    step();
    step();
    chk("wait_m0_served", 32'(m_ack_o), 32'h1);
    all_idle();

    // Unmapped address from master 2: one-cycle error, then back in GRANT.
    set_m(2, 32'hE000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    chk("err_no_stb", 32'(s_stb_o), 32'h0);
    chk("err_no_cyc", 32'(s_cyc_o), 32'h0);
    chk("err_not_yet", 32'(m_err_o), 32'h0);
    step();
    chk("err_pulse", 32'(m_err_o), 32'h4);
    chk("err_pulse_nostb", 32'(s_stb_o), 32'h0);
    chk("err_pulse_noack", 32'(m_ack_o), 32'h0);
    set_m(2, 32'hE000_0000, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    chk("err_one_cycle", 32'(m_err_o), 32'h0);
    ack_auto = 1'b1;
    set_m(2, 32'h4000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("err_back_grant_ack", 32'(m_ack_o), 32'h4);
    chk("err_back_grant_stb", 32'(s_stb_o), 32'h4);
    set_m(2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    all_idle();

    // Silent slave on master 3.
    set_m(3, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    n_stb = 0;
    got_err = 0;
    for (int c = 0; c < 40 && got_err == 0; c++) begin
      step();
      if (m_err_o != '0) got_err = 1;
      else if (s_stb_o != '0) n_stb++;
    end
`ifdef WB_CONBUS_TIMEOUT_EN
    chk("wd_err_seen", 32'(got_err), 32'h1);
    chk("wd_stb_cycles", 32'(n_stb), 32'(TO));
    chk("wd_err_master", 32'(m_err_o), 32'h8);
    chk("wd_stb_drop", 32'(s_stb_o), 32'h0);
`else
    chk("stall_no_err", 32'(got_err), 32'h0);
    chk("stall_stb_cycles", 32'(n_stb), 32'd40);
    chk("stall_stb_held", 32'(s_stb_o), 32'h1);
`endif
    set_m(3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    all_idle();

    // Master 1 holds its cycle for 3 beats while master 0 requests.
    ack_auto = 1'b1;
    set_m(1, 32'h2000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    set_m(0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("hold_beat0", 32'(m_ack_o), 32'h2);
    step();
    chk("hold_beat1", 32'(m_ack_o), 32'h2);
    step();
    chk("hold_beat2", 32'(m_ack_o), 32'h2);
    step();
    set_m(1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hold_fall_cyc", 32'(s_cyc_o), 32'h0);
    chk("hold_fall_ack", 32'(m_ack_o), 32'h0);
    step();
    chk("hold_idle_cyc", 32'(s_cyc_o), 32'h0);
    step();
    chk("hold_m0_ack", 32'(m_ack_o), 32'h1);
    chk("hold_m0_stb", 32'(s_stb_o), 32'h1);

    // Finish master 0 (last_grant=0), then reset while master 1 is mid-beat.
    step();
    set_m(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    set_m(1, 32'h2000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    step();
    chk("mid_beat_ack", 32'(m_ack_o), 32'h2);
    set_m(0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    chk_quiet("mid_rst");
    chk("mid_rst_m_dat", m_dat_o, 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_m0_wins", 32'(m_ack_o), 32'h1);
    chk("post_rst_m0_stb", 32'(s_stb_o), 32'h1);

    // Fresh reset, then masters 0..2 request continuously with 1-beat cycles.
    m_cyc_i = '0;
    m_stb_i = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ack_auto = 1'b1;
    drop = '0;
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      for (int i = 0; i < 3; i++)
        set_m(i, 32'(i) << 29, 32'h0, 1'b0, !drop[i], !drop[i]);
      drop = '0;
      #1;
      if (m_ack_o != '0) begin
        idx = 0;
        for (int i = 0; i < NM; i++) if (m_ack_o[i]) idx = i;
        chk("rr_onehot", 32'($onehot(m_ack_o)), 32'h1);
        chk("rr_dat", m_dat_o, 32'hA000_0000 | 32'(idx));
        order[ngr] = idx;
        ngr++;
        if (idx < 3) drop[idx] = 1'b1;
      end
      step();
    end
    chk("rr_count", 32'(ngr), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < ngr) chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 3));
    all_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
